// File: rtl/rps_move_capture.sv
// rps_move_capture: syncs and debounces six buttons and locks each player's first move; `RPS_CPU_OPPONENT_EN swaps player 2 for an LFSR opponent.
// Latency: a stable raw press locks DEBOUNCE_CYCLES+3 edges later; PRESENT follows the edge after both players are locked.
// Backpressure: moves held in PRESENT until round_ack; press events arriving outside COLLECT are dropped, never queued.
module rps_move_capture #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DB_W            = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_rock1,
    input  logic       btn_paper1,
    input  logic       btn_scissors1,
    input  logic       btn_rock2,
    input  logic       btn_paper2,
    input  logic       btn_scissors2,
    input  logic       round_ack,
    output logic       rock1,
    output logic       paper1,
    output logic       scissors1,
    output logic       rock2,
    output logic       paper2,
    output logic       scissors2,
    output logic       round_valid,
    output logic       lock1,
    output logic       lock2,
    output logic [3:0] round_cnt
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        PRESENT = 2'd1,
        CLEAR   = 2'd2
    } state_t;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Bit order per player: [0]=rock, [1]=paper, [2]=scissors; player 2 in [5:3].
    logic [5:0]      raw;
    logic [5:0]      sync1;
    logic [5:0]      sync2;
    logic [5:0]      db;
    logic [5:0]      db_q;
    logic [5:0]      press;
    logic [DB_W-1:0] db_cnt [6];

    state_t     state;
    state_t     state_nxt;
    logic       lock1_q;
    logic       lock2_q;
    logic [2:0] mv1_q;
    logic [2:0] mv2_q;
    logic [3:0] cnt_q;
    logic       p1_take;
    logic       p2_take;
    logic [2:0] p2_mv;

    assign raw = {btn_scissors2, btn_paper2, btn_rock2,
                  btn_scissors1, btn_paper1, btn_rock1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 6; i++) begin
                db_cnt[i] <= '0;
            end
            db   <= '0;
            db_q <= '0;
        end else begin
            db_q <= db;
            for (int i = 0; i < 6; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db_cnt[i] <= '0;
                    db[i]     <= ~db[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = db & ~db_q;

    // A player's press only counts when exactly one of their buttons fired this cycle.
    assign p1_take = (press[2:0] == 3'b001) || (press[2:0] == 3'b010) || (press[2:0] == 3'b100);

`ifdef RPS_CPU_OPPONENT_EN
    logic [15:0] lfsr;
    logic        unused_btn2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign p2_take     = lock1_q && (lfsr[1:0] != 2'd3);
    assign unused_btn2 = ^press[5:3];

    always_comb begin
        p2_mv = 3'b100;
        case (lfsr[1:0])
            2'd0:    p2_mv = 3'b001;
            2'd1:    p2_mv = 3'b010;
            default: p2_mv = 3'b100;
        endcase
    end
`else
    assign p2_take = (press[5:3] == 3'b001) || (press[5:3] == 3'b010) || (press[5:3] == 3'b100);
    assign p2_mv   = press[5:3];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (lock1_q && lock2_q) state_nxt = PRESENT;
            PRESENT: if (round_ack) state_nxt = CLEAR;
            CLEAR:   state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock1_q <= 1'b0;
            lock2_q <= 1'b0;
            mv1_q   <= '0;
            mv2_q   <= '0;
            cnt_q   <= '0;
        end else if (state == PRESENT && round_ack) begin
            lock1_q <= 1'b0;
            lock2_q <= 1'b0;
            mv1_q   <= '0;
            mv2_q   <= '0;
            cnt_q   <= cnt_q + 4'd1;
        end else if (state == COLLECT) begin
            if (!lock1_q && p1_take) begin
                lock1_q <= 1'b1;
                mv1_q   <= press[2:0];
            end
            if (!lock2_q && p2_take) begin
                lock2_q <= 1'b1;
                mv2_q   <= p2_mv;
            end
        end
    end

    always_comb begin
        round_valid = 1'b0;
        rock1       = 1'b0;
        paper1      = 1'b0;
        scissors1   = 1'b0;
        rock2       = 1'b0;
        paper2      = 1'b0;
        scissors2   = 1'b0;
        if (state == PRESENT) begin
            round_valid                = 1'b1;
            {scissors1, paper1, rock1} = mv1_q;
            {scissors2, paper2, rock2} = mv2_q;
        end
    end

    assign lock1     = lock1_q;
    assign lock2     = lock2_q;
    assign round_cnt = cnt_q;

endmodule

// File: tb/tb_rps_move_capture.sv
// Bench for rps_move_capture: randomized button/ack stimulus checked every cycle against a rule-level model of the game front end.
`timescale 1ns/1ps
module tb_rps_move_capture;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] btn = '0;
    logic       round_ack = 1'b0;
    logic       rock1, paper1, scissors1, rock2, paper2, scissors2;
    logic       round_valid, lock1, lock2;
    logic [3:0] round_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rps_move_capture #(.DEBOUNCE_CYCLES(N), .DB_W(4)) dut (
        .clk(clk), .rst(rst),
        .btn_rock1(btn[0]), .btn_paper1(btn[1]), .btn_scissors1(btn[2]),
        .btn_rock2(btn[3]), .btn_paper2(btn[4]), .btn_scissors2(btn[5]),
        .round_ack(round_ack),
        .rock1(rock1), .paper1(paper1), .scissors1(scissors1),
        .rock2(rock2), .paper2(paper2), .scissors2(scissors2),
        .round_valid(round_valid), .lock1(lock1), .lock2(lock2),
        .round_cnt(round_cnt)
    );

    wire [12:0] dut_vec = {round_valid, rock1, paper1, scissors1, rock2, paper2, scissors2,
                           lock1, lock2, round_cnt};

    // Reference model: raw samples per edge, a level is accepted once N synced samples in a row disagree.
    bit          m_hist[6][$];
    bit          m_db[6];
    bit          m_press[6];
    int          m_phase;   // 0 collecting, 1 presenting, 2 clearing
    bit          m_lock1, m_lock2;
    int          m_mv1, m_mv2;   // 0 rock, 1 paper, 2 scissors
    int          m_cnt;
    logic [15:0] m_lfsr;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            for (int b = 0; b < 6; b++) begin
                m_hist[b].delete();
                m_db[b]    = 1'b0;
                m_press[b] = 1'b0;
            end
            m_phase = 0; m_lock1 = 1'b0; m_lock2 = 1'b0;
            m_mv1 = 0; m_mv2 = 0; m_cnt = 0; m_lfsr = 16'hACE1;
        end else begin : step
            int n1, n2, w1, w2, sz;
            bit both, l1_before, all_diff, s;
            n1 = 0; n2 = 0; w1 = 0; w2 = 0;
            for (int b = 0; b < 3; b++) begin
                if (m_press[b])     begin n1++; w1 = b; end
                if (m_press[b + 3]) begin n2++; w2 = b; end
            end
            if (m_phase == 0) begin
                both      = m_lock1 && m_lock2;
                l1_before = m_lock1;
                if (!m_lock1 && n1 == 1) begin m_lock1 = 1'b1; m_mv1 = w1; end
`ifdef RPS_CPU_OPPONENT_EN
                if (!m_lock2 && l1_before && m_lfsr[1:0] != 2'd3) begin
                    m_lock2 = 1'b1; m_mv2 = int'(m_lfsr[1:0]);
                end
`else
                if (!m_lock2 && n2 == 1) begin m_lock2 = 1'b1; m_mv2 = w2; end
`endif
                if (both) m_phase = 1;
            end else if (m_phase == 1) begin
                if (round_ack) begin
                    m_phase = 2; m_lock1 = 1'b0; m_lock2 = 1'b0; m_cnt = (m_cnt + 1) % 16;
                end
            end else begin
                m_phase = 0;
            end
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            for (int b = 0; b < 6; b++) begin
                sz       = m_hist[b].size();
                all_diff = 1'b1;
                for (int k = 2; k <= N + 1; k++) begin
                    s = (sz >= k) ? m_hist[b][sz - k] : 1'b0;
                    if (s == m_db[b]) all_diff = 1'b0;
                end
                m_press[b] = all_diff && !m_db[b];
                if (all_diff) m_db[b] = !m_db[b];
                m_hist[b].push_back(btn[b]);
                if (m_hist[b].size() > N + 2) void'(m_hist[b].pop_front());
            end
        end
    end

    function automatic logic [12:0] exp_vec();
        logic [2:0] p1, p2;
        p1 = 3'b000;
        p2 = 3'b000;
        if (m_phase == 1) begin
            p1 = 3'b100 >> m_mv1;
            p2 = 3'b100 >> m_mv2;
        end
        return {m_phase == 1, p1, p2, m_lock1, m_lock2, 4'(m_cnt)};
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        btn = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec !== 13'd0) begin errors++; $display("FAIL reset_state: dut=%b want=%b", dut_vec, 13'd0); end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL reset_release: dut=%b model=%b", dut_vec, exp_vec()); end
        end
    endtask

    task automatic test_basic();
        bit got;
        btn[0] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL basic_cycle: dut=%b model=%b", dut_vec, exp_vec()); end
            if (i <= 8) begin
                checks++;
                if (lock1 !== (i >= 7)) begin errors++; $display("FAIL lock_latency: cycle %0d lock1=%b want=%b", i, lock1, i >= 7); end
            end
        end
        btn[0] = 1'b0;
        btn[5] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL basic_wait: dut=%b model=%b", dut_vec, exp_vec()); end
            got = (round_valid === 1'b1);
        end
        checks++;
        if (!got) begin errors++; $display("FAIL basic_timeout: round_valid=%b want=1", round_valid); end
`ifdef RPS_CPU_OPPONENT_EN
        checks++;
        if ({rock1, paper1, scissors1} !== 3'b100) begin errors++; $display("FAIL basic_moves: p1=%b want=100", {rock1, paper1, scissors1}); end
`else
        checks++;
        if ({rock1, paper1, scissors1, rock2, paper2, scissors2} !== 6'b100001) begin
            errors++; $display("FAIL basic_moves: moves=%b want=100001", {rock1, paper1, scissors1, rock2, paper2, scissors2});
        end
`endif
        round_ack = 1'b1;
        @(negedge clk);
        round_ack = 1'b0;
        checks++;
        if ({round_valid, rock1, scissors2, lock1, lock2, round_cnt} !== {5'b00000, 4'd1}) begin
            errors++; $display("FAIL basic_ack: valid=%b lock1=%b lock2=%b cnt=%0d want 0,0,0,1", round_valid, lock1, lock2, round_cnt);
        end
        btn = '0;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL basic_settle: dut=%b model=%b", dut_vec, exp_vec()); end
        end
    endtask

    task automatic test_bounce();
        int  pulses;
        bit  got;
        pulses = $urandom_range(2, 4);
        for (int p = 0; p < pulses; p++) begin
            btn[1] = 1'b1;
            repeat (2) begin
                @(negedge clk);
                checks++;
                if (dut_vec !== exp_vec() || lock1 !== 1'b0) begin errors++; $display("FAIL bounce_high: dut=%b model=%b", dut_vec, exp_vec()); end
            end
            btn[1] = 1'b0;
            repeat ($urandom_range(1, 5)) begin
                @(negedge clk);
                checks++;
                if (dut_vec !== exp_vec() || lock1 !== 1'b0) begin errors++; $display("FAIL bounce_low: dut=%b model=%b", dut_vec, exp_vec()); end
            end
        end
        btn[1] = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            checks++;
            if (lock1 !== (i >= 7) || dut_vec !== exp_vec()) begin
                errors++; $display("FAIL bounce_settle: cycle %0d lock1=%b dut=%b model=%b", i, lock1, dut_vec, exp_vec());
            end
        end
        btn[3 + $urandom_range(0, 2)] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL bounce_wait: dut=%b model=%b", dut_vec, exp_vec()); end
            got = (round_valid === 1'b1);
        end
        checks++;
        if (!got || {rock1, paper1, scissors1} !== 3'b010) begin
            errors++; $display("FAIL bounce_present: valid=%b p1=%b want 1,010", round_valid, {rock1, paper1, scissors1});
        end
        repeat ($urandom_range(0, 5)) @(negedge clk);
        round_ack = 1'b1;
        @(negedge clk);
        round_ack = 1'b0;
        btn = '0;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL bounce_after: dut=%b model=%b", dut_vec, exp_vec()); end
        end
    endtask

    task automatic test_first_wins();
        bit got;
        btn[0] = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (lock1 !== 1'b1) begin errors++; $display("FAIL first_lock: lock1=%b want=1", lock1); end
        btn[0] = 1'b0;
        btn[2] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL first_change: dut=%b model=%b", dut_vec, exp_vec()); end
        end
`ifndef RPS_CPU_OPPONENT_EN
        btn[3] = 1'b1;
        btn[4] = 1'b1;
        repeat (12) begin
            @(negedge clk);
            checks++;
            if (lock2 !== 1'b0 || dut_vec !== exp_vec()) begin errors++; $display("FAIL dual_press: lock2=%b dut=%b model=%b", lock2, dut_vec, exp_vec()); end
        end
        btn[3] = 1'b0;
        btn[4] = 1'b0;
        repeat (10) @(negedge clk);
        btn[5] = 1'b1;
`endif
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL first_wait: dut=%b model=%b", dut_vec, exp_vec()); end
            got = (round_valid === 1'b1);
        end
        checks++;
        if (!got || {rock1, paper1, scissors1} !== 3'b100) begin
            errors++; $display("FAIL first_kept: valid=%b p1=%b want 1,100", round_valid, {rock1, paper1, scissors1});
        end
        round_ack = 1'b1;
        @(negedge clk);
        round_ack = 1'b0;
        btn = '0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_hold_ack();
        bit          got;
        logic [12:0] snap;
        btn[$urandom_range(0, 2)]     = 1'b1;
        btn[3 + $urandom_range(0, 2)] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (round_valid === 1'b1);
        end
        checks++;
        if (!got || dut_vec !== exp_vec()) begin errors++; $display("FAIL hold_enter: dut=%b model=%b", dut_vec, exp_vec()); end
        snap = exp_vec();
        for (int i = 0; i < 58; i++) begin
            if (i < 50) begin
                for (int b = 0; b < 6; b++) if ($urandom_range(0, 7) == 0) btn[b] = ~btn[b];
            end else begin
                btn = '0;
            end
            @(negedge clk);
            checks++;
            if (dut_vec !== snap) begin errors++; $display("FAIL hold_stable: cycle %0d dut=%b want=%b", i, dut_vec, snap); end
        end
        round_ack = 1'b1;
        @(negedge clk);
        round_ack = 1'b0;
        repeat (15) begin
            @(negedge clk);
            checks++;
            if (lock1 !== 1'b0 || lock2 !== 1'b0 || dut_vec !== exp_vec()) begin
                errors++; $display("FAIL no_queue: lock1=%b lock2=%b dut=%b model=%b", lock1, lock2, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_wrap_reset();
        bit got;
        int start;
        rst = 1'b0;
        btn = 6'b000010;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            checks++;
            if (lock1 !== (i >= 7) || dut_vec !== exp_vec()) begin
                errors++; $display("FAIL held_through_reset: cycle %0d lock1=%b dut=%b model=%b", i, lock1, dut_vec, exp_vec());
            end
        end
        for (int r = 0; r < 17; r++) begin
            btn = '0;
            btn[$urandom_range(0, 2)]     = 1'b1;
            btn[3 + $urandom_range(0, 2)] = 1'b1;
            start = m_cnt;
            got   = 1'b0;
            for (int c = 0; c < 80 && !got; c++) begin
                round_ack = ($urandom_range(0, 3) == 0);
                @(negedge clk);
                checks++;
                if (dut_vec !== exp_vec()) begin errors++; $display("FAIL round_cycle: round %0d dut=%b model=%b", r, dut_vec, exp_vec()); end
                got = (m_cnt != start);
            end
            round_ack = 1'b0;
            checks++;
            if (!got) begin errors++; $display("FAIL round_timeout: round %0d cnt=%0d", r, round_cnt); end
            btn = '0;
            repeat (10) @(negedge clk);
        end
        checks++;
        if (round_cnt !== 4'd1) begin errors++; $display("FAIL cnt_wrap: round_cnt=%0d want=1", round_cnt); end
        btn[0] = 1'b1;
        btn[4] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (round_valid === 1'b1);
        end
        checks++;
        if (!got) begin errors++; $display("FAIL midround_present: round_valid=%b want=1", round_valid); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (dut_vec !== 13'd0) begin errors++; $display("FAIL async_reset: dut=%b want=%b", dut_vec, 13'd0); end
        btn = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin errors++; $display("FAIL post_reset: dut=%b model=%b", dut_vec, exp_vec()); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_bounce();
        test_first_wins();
        test_hold_ack();
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
